line_window_buffer: RTL

- Parametrised multi-line pixel buffer that presents a vertical column of NUM_ROWS pixels per accepted input pixel:
  - the current pixel;
  - the same column 1..NUM_ROWS-1 lines earlier.
- Sits between the camera pixel stream and the 2-D convolution/edge-filter stages, replacing the fixed 3x640 shift chain.
- Adds a runtime line length, start-of-frame realignment, line-fill status and per-tap sideband flags.

---
 rtl/line_window_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - multi-line pixel buffer presenting a NUM_ROWS vertical tap column per accepted pixel
// Optional macro LINEBUF_ZERO_FILL_EN: taps for lines not yet written since SOF/reset read as zero.
module line_window_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int MAX_LINE   = 640,
  parameter int NUM_ROWS   = 3,
  parameter int LEN_W      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LEN_W-1:0]               line_len,
  input  logic [DATA_WIDTH-1:0]          pixel_in,
  input  logic                           pixel_valid,
  input  logic                           pixel_sof,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] tap_data,
  output logic                           tap_valid,
  output logic                           tap_sol,
  output logic                           tap_eol,
  output logic [LEN_W-1:0]               tap_col,
  output logic [$clog2(NUM_ROWS+1)-1:0]  rows_filled,
  output logic                           window_ready
);

  localparam int RF_W = $clog2(NUM_ROWS + 1);
  localparam int NMEM = NUM_ROWS - 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);
  localparam logic [RF_W-1:0]  FILL_SAT = RF_W'(NUM_ROWS - 1);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len == '0 || len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [NMEM][MAX_LINE];

  // Line-memory shifts are written one cycle after the read, so a same-column
  // read in that cycle must take the pending write data instead of the array.
  logic                  r_wr_en;
  logic [LEN_W-1:0]      r_wr_col;
  logic [DATA_WIDTH-1:0] r_wr_data [NMEM];

  logic [LEN_W-1:0]      r_col;
  logic [LEN_W-1:0]      r_len;
  logic [RF_W-1:0]       r_fill;
  logic [DATA_WIDTH-1:0] r_tap [NUM_ROWS];
  logic                  r_valid;
  logic                  r_sol;
  logic                  r_eol;
  logic [LEN_W-1:0]      r_tcol;
  logic [RF_W-1:0]       r_rows;
  logic                  r_ready;

  logic                  w_accept;
  logic [LEN_W-1:0]      w_col;
  logic [LEN_W-1:0]      w_len;
  logic [RF_W-1:0]       w_fill;
  logic [RF_W-1:0]       w_rows;
  logic                  w_last;
  logic                  w_byp;
  logic [DATA_WIDTH-1:0] w_rd [NMEM];

  always_comb begin
    w_accept = pixel_valid && !rst;
    w_col    = pixel_sof ? '0 : r_col;
    w_len    = pixel_sof ? clamp_len(line_len) : r_len;
    w_fill   = pixel_sof ? '0 : r_fill;
    w_rows   = w_fill + 1'b1;
    w_last   = (w_col == w_len - 1'b1);
    w_byp    = r_wr_en && (r_wr_col == w_col);
    for (int k = 0; k < NMEM; k++) begin
      w_rd[k] = w_byp ? r_wr_data[k] : r_mem[k][w_col];
    end
  end

  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      for (int k = 0; k < NMEM; k++) begin
        r_mem[k][r_wr_col] <= r_wr_data[k];
      end
    end
  end

  // The pending write is deliberately outside the reset branch so a pixel
  // accepted just before reset still lands in the line memory.
  always_ff @(posedge clk) begin
    r_wr_en <= w_accept;
    if (w_accept) begin
      r_wr_col     <= w_col;
      r_wr_data[0] <= pixel_in;
      for (int k = 1; k < NMEM; k++) begin
        r_wr_data[k] <= w_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_fill  <= '0;
      r_len   <= clamp_len(line_len);
      r_valid <= 1'b0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_tcol  <= '0;
      r_rows  <= '0;
      r_ready <= 1'b0;
      for (int k = 0; k < NUM_ROWS; k++) begin
        r_tap[k] <= '0;
      end
    end else begin
      r_valid <= pixel_valid;
      if (pixel_valid) begin
        r_tap[0] <= pixel_in;
        for (int k = 1; k < NUM_ROWS; k++) begin
`ifdef LINEBUF_ZERO_FILL_EN
          r_tap[k] <= (RF_W'(k) >= w_rows) ? '0 : w_rd[k-1];
`else
          r_tap[k] <= w_rd[k-1];
`endif
        end
        r_tcol  <= w_col;
        r_sol   <= (w_col == '0);
        r_eol   <= w_last;
        r_rows  <= w_rows;
        r_ready <= (w_rows == RF_W'(NUM_ROWS));
        r_len   <= w_len;
        if (w_last) begin
          r_col  <= '0;
          r_fill <= (w_fill == FILL_SAT) ? w_fill : w_fill + 1'b1;
        end else begin
          r_col  <= w_col + 1'b1;
          r_fill <= w_fill;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_tap
    assign tap_data[g*DATA_WIDTH +: DATA_WIDTH] = r_tap[g];
  end

  assign tap_valid    = r_valid;
  assign tap_sol      = r_sol;
  assign tap_eol      = r_eol;
  assign tap_col      = r_tcol;
  assign rows_filled  = r_rows;
  assign window_ready = r_ready;

endmodule
